mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_watchdog.sv | 49 ++++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the two-requester memory arbiter.
// Pure declarations; no timing of its own.
// No flow control here; consumers own the handshake.
package mem_arbiter_pkg;

    localparam int ARB_WIDTH_DEFAULT   = 32;
    localparam int ARB_TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// arb_watchdog: counts BUSY cycles and flags an expired memory access.
// expire is combinational in the TIMEOUT-th cycle after start.
// Stops counting once ready or expire is seen; start re-arms and clears.
module arb_watchdog
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ready,
    output logic expire
);

    logic [7:0] cnt_q, cnt_d;
    logic       active_q, active_d;

    // Expire in the last allowed cycle only if the memory has not answered.
    assign expire = active_q & ~ready & (cnt_q == 8'(TIMEOUT - 1));

    // Clear on start, count while armed, disarm on completion or expiry.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            cnt_d    = 8'd0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (ready || expire) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Counter and armed-flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= 8'd0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data-stage requests onto one single-port memory (optional MEM_ARB_TIMEOUT_EN watchdog).
// Latency: 3 cycles minimum (IDLE sample, BUSY, RESP ack); one transaction in flight.
// Losers and in-flight owners see stall until their ack; mem_req is held until mem_ready.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH   = ARB_WIDTH_DEFAULT,
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic             if_ack,
    output logic [WIDTH-1:0] if_rdata,
    input  logic             dm_req,
    input  logic             dm_we,
    input  logic [WIDTH-1:0] dm_addr,
    input  logic [WIDTH-1:0] dm_wdata,
    output logic             dm_ack,
    output logic [WIDTH-1:0] dm_rdata,
    output logic             if_stall,
    output logic             dm_stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             err
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
        $error("mem_arbiter: TIMEOUT must lie in 2..255");
    end

    arb_state_e       state_q, state_d;
    owner_e           owner_q, owner_d;
    owner_e           last_gnt_q, last_gnt_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    logic             gnt_dm;
    logic             expire;
    logic             wd_start;

    assign wd_start = (state_q == ARB_IDLE) & (if_req | dm_req);

`ifdef MEM_ARB_TIMEOUT_EN
    logic err_q;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .start  (wd_start),
        .ready  (mem_ready & (state_q == ARB_BUSY)),
        .expire (expire)
    );

    // err is high for the single RESP cycle that follows an expiry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= expire;
        end
    end

    assign err = err_q;
`else
    assign expire = 1'b0;
    assign err    = 1'b0;
`endif

    // Arbitration, latching and response sequencing.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        // dm wins when alone, or on contention if fetch had the last grant.
        gnt_dm     = dm_req & (~if_req | (last_gnt_q == OWN_IF));
        case (state_q)
            ARB_IDLE: begin
                if (if_req || dm_req) begin
                    state_d = ARB_BUSY;
                    if (gnt_dm) begin
                        owner_d = OWN_DM;
                        addr_d  = dm_addr;
                        wdata_d = dm_wdata;
                        we_d    = dm_we;
                    end else begin
                        owner_d = OWN_IF;
                        addr_d  = if_addr;
                        wdata_d = '0;
                        we_d    = 1'b0;
                    end
                end
            end
            ARB_BUSY: begin
                if (mem_ready) begin
                    state_d = ARB_RESP;
                    // Writes complete without disturbing the data-stage read value.
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                    end else if (!we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end else if (expire) begin
                    state_d = ARB_RESP;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = '0;
                    end else if (!we_q) begin
                        dm_rdata_d = '0;
                    end
                end
            end
            ARB_RESP: begin
                last_gnt_d = owner_q;
                state_d    = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_IF;
            last_gnt_q <= OWN_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign mem_req   = (state_q == ARB_BUSY);
    assign mem_we    = (state_q == ARB_BUSY) & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ack    = (state_q == ARB_RESP) & (owner_q == OWN_IF);
    assign dm_ack    = (state_q == ARB_RESP) & (owner_q == OWN_DM);
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_stall  = if_req & ~if_ack;
    assign dm_stall  = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, lone fetch, contention, fairness, slow memory, mid-busy reset.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// The timeout scenario is compiled in only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we, mem_ready;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic        if_ack, dm_ack, if_stall, dm_stall, mem_req, mem_we, err;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .if_stall(if_stall), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        tick(); tick();
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        n_cmp++; if ({if_ack, dm_ack} !== 2'b00) begin n_fail++; $display("FAIL rst_acks: got %b want 00", {if_ack, dm_ack}); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
        n_cmp++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h/%h want 0/0", if_rdata, dm_rdata); end
        n_cmp++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_bus: got %h/%h want 0/0", mem_addr, mem_wdata); end
        rst = 1'b1;
        tick();
    endtask

    // Lone fetch with memory answering in the first BUSY cycle: IDLE, BUSY, RESP.
    task automatic test_single_fetch();
        if_req = 1; if_addr = 32'h40; mem_ready = 1; mem_rdata = 32'h1234ABCD;
        #1;
        n_cmp++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_idle: got %b want 1", if_stall); end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_busy: req %b addr %h we %b want 1 40 0", mem_req, mem_addr, mem_we); end
        n_cmp++; if (if_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_early_ack: got %b want 0", if_ack); end
        tick();
        n_cmp++; if (if_ack !== 1'b1 || dm_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_ack_cycle3: if %b dm %b want 1 0", if_ack, dm_ack); end
        n_cmp++; if (if_rdata !== 32'h1234ABCD) begin n_fail++; $display("FAIL fetch_rdata: got %h want 1234abcd", if_rdata); end
        n_cmp++; if (if_stall !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_resp_stall: stall %b mem_req %b want 0 0", if_stall, mem_req); end
        if_req = 0; mem_ready = 0; mem_rdata = 32'hFFFFFFFF;
        tick();
        n_cmp++; if (if_ack !== 1'b0 || if_rdata !== 32'h1234ABCD) begin n_fail++; $display("FAIL fetch_hold: ack %b rdata %h want 0 1234abcd", if_ack, if_rdata); end
    endtask

    // Simultaneous requests after reset: data-stage write first, then fetch.
    task automatic test_contention();
        rst = 0; tick(); rst = 1; tick();
        if_req = 1; if_addr = 32'h200;
        dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
        tick();
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cont_dm_first: we %b addr %h wdata %h want 1 100 deadbeef", mem_we, mem_addr, mem_wdata); end
        n_cmp++; if (if_stall !== 1'b1 || dm_stall !== 1'b1) begin n_fail++; $display("FAIL cont_stalls: if %b dm %b want 1 1", if_stall, dm_stall); end
        mem_ready = 1; mem_rdata = 32'h55555555;
        tick();
        n_cmp++; if (dm_ack !== 1'b1 || if_ack !== 1'b0) begin n_fail++; $display("FAIL cont_dm_ack: dm %b if %b want 1 0", dm_ack, if_ack); end
        n_cmp++; if (dm_rdata !== 32'h0) begin n_fail++; $display("FAIL cont_write_rdata: got %h want 0", dm_rdata); end
        dm_req = 0; dm_we = 0; mem_ready = 0;
        tick();
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h200 || mem_we !== 1'b0) begin n_fail++; $display("FAIL cont_if_second: req %b addr %h we %b want 1 200 0", mem_req, mem_addr, mem_we); end
        mem_ready = 1; mem_rdata = 32'hCAFEF00D;
        tick();
        n_cmp++; if (if_ack !== 1'b1 || if_rdata !== 32'hCAFEF00D || dm_rdata !== 32'h0) begin n_fail++; $display("FAIL cont_if_ack: ack %b rdata %h dm_rdata %h want 1 cafef00d 0", if_ack, if_rdata, dm_rdata); end
        if_req = 0; mem_ready = 0;
        tick();
    endtask

    // Both requesters held high; last grant was fetch, so dm, IF, dm, IF.
    task automatic test_back_to_back();
        logic        exp_dm;
        logic [31:0] exp_data;
        if_req = 1; if_addr = 32'h400; dm_req = 1; dm_we = 0; dm_addr = 32'h300; mem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            exp_dm   = (i % 2 == 0);
            exp_data = 32'hA0000000 + 32'(i);
            mem_rdata = exp_data;
            tick();
            n_cmp++; if (mem_addr !== (exp_dm ? 32'h300 : 32'h400)) begin n_fail++; $display("FAIL alt_addr[%0d]: got %h want %h", i, mem_addr, exp_dm ? 32'h300 : 32'h400); end
            tick();
            n_cmp++; if (dm_ack !== exp_dm || if_ack !== !exp_dm) begin n_fail++; $display("FAIL alt_ack[%0d]: dm %b if %b want %b %b", i, dm_ack, if_ack, exp_dm, !exp_dm); end
            n_cmp++; if ((exp_dm ? dm_rdata : if_rdata) !== exp_data) begin n_fail++; $display("FAIL alt_rdata[%0d]: got %h want %h", i, exp_dm ? dm_rdata : if_rdata, exp_data); end
            tick();
        end
        if_req = 0; dm_req = 0; mem_ready = 0;
        tick();
    endtask

    // Memory answers in the 5th BUSY cycle; request changes mid-flight are ignored.
    task automatic test_slow_memory();
        dm_req = 1; dm_we = 0; dm_addr = 32'h500; mem_ready = 0; mem_rdata = 32'h0BADF00D;
        tick();
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h500 || dm_stall !== 1'b1 || dm_ack !== 1'b0) begin n_fail++; $display("FAIL slow_busy[%0d]: req %b addr %h stall %b ack %b want 1 500 1 0", k, mem_req, mem_addr, dm_stall, dm_ack); end
            if (k == 1) dm_addr = 32'hFFF;
            if (k == 4) mem_ready = 1;
            tick();
        end
        n_cmp++; if (dm_ack !== 1'b1 || dm_rdata !== 32'h0BADF00D) begin n_fail++; $display("FAIL slow_ack: ack %b rdata %h want 1 0badf00d", dm_ack, dm_rdata); end
`ifndef MEM_ARB_TIMEOUT_EN
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL slow_err: got %b want 0", err); end
`endif
        dm_req = 0; mem_ready = 0;
        tick();
    endtask

    // Reset mid-BUSY: mem_req drops at once, no ack, restart from IDLE.
    task automatic test_reset_busy();
        if_req = 1; if_addr = 32'h600; mem_ready = 0; mem_rdata = 32'h600D600D;
        tick();
        n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rb_busy: got %b want 1", mem_req); end
        rst = 0;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || if_ack !== 1'b0 || if_rdata !== 32'h1234ABCD - 32'h1234ABCD + if_rdata_exp_reset()) begin n_fail++; $display("FAIL rb_async: req %b ack %b rdata %h want 0 0 0", mem_req, if_ack, if_rdata); end
        mem_ready = 1;
        tick();
        rst = 1;
        #1;
        n_cmp++; if (if_ack !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rb_no_ack: ack %b req %b want 0 0", if_ack, mem_req); end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h600) begin n_fail++; $display("FAIL rb_restart: req %b addr %h want 1 600", mem_req, mem_addr); end
        tick();
        n_cmp++; if (if_ack !== 1'b1 || if_rdata !== 32'h600D600D) begin n_fail++; $display("FAIL rb_ack: ack %b rdata %h want 1 600d600d", if_ack, if_rdata); end
        if_req = 0; mem_ready = 0;
        tick();
    endtask

    function automatic logic [31:0] if_rdata_exp_reset();
        return 32'h0;
    endfunction

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: err and ack with zero data after 16 BUSY cycles.
    task automatic test_timeout();
        dm_req = 1; dm_we = 0; dm_addr = 32'h700; mem_ready = 0; mem_rdata = 32'h77777777;
        tick();
        for (int k = 1; k <= 16; k++) begin
            n_cmp++; if (mem_req !== 1'b1 || err !== 1'b0 || dm_ack !== 1'b0) begin n_fail++; $display("FAIL to_busy[%0d]: req %b err %b ack %b want 1 0 0", k, mem_req, err, dm_ack); end
            tick();
        end
        n_cmp++; if (err !== 1'b1 || dm_ack !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL to_expire: err %b ack %b req %b want 1 1 0", err, dm_ack, mem_req); end
        n_cmp++; if (dm_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h want 0", dm_rdata); end
        dm_req = 0;
        tick();
        n_cmp++; if (err !== 1'b0 || dm_ack !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL to_idle: err %b ack %b req %b want 0 0 0", err, dm_ack, mem_req); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_back_to_back();
        test_slow_memory();
        test_reset_busy();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
